// File: rtl/fpu_share_arbiter_pkg.sv
// fpu_share_arbiter_pkg: shared types and defaults for the FPU share arbiter
package fpu_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef logic [2:0] fpu_op_t;
  typedef logic [1:0] fpu_rmode_t;
  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/fpu_rr_arb.sv
// fpu_rr_arb: combinational round-robin grant, searching upward from ptr+1
module fpu_rr_arb #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);
  // Walk candidates farthest-first so the nearest one after ptr wins
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
  end
  assign any_req = |req;
  assign grant = any_req ? N'(1) << idx : '0;
endmodule

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one FPU among NUM_REQ requesters.
// Optional watchdog in WAIT enabled by FPU_ARB_TIMEOUT_EN.
module fpu_share_arbiter
  import fpu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FP_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*3-1:0]         req_op,
  input  logic [NUM_REQ*2-1:0]         req_rmode,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [FP_WIDTH-1:0]          rsp_result,
  output logic                         rsp_err,
  output logic                         fpu_start,
  output fpu_op_t                      fpu_op,
  output fpu_rmode_t                   fpu_rmode,
  output logic [FP_WIDTH-1:0]          fpu_a,
  output logic [FP_WIDTH-1:0]          fpu_b,
  input  logic                         fpu_ready,
  input  logic [FP_WIDTH-1:0]          fpu_result,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fpu_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end
  state_t state, state_n;
  logic [IW-1:0] ptr, idx;
  logic [NUM_REQ-1:0] grant;
  logic any_req, tmo, done;
  fpu_rr_arb #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .any_req(any_req)
  );
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  // Counter idles at zero, so it starts from zero on every WAIT entry
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == WAIT ? cnt + 1'b1 : '0;
  assign tmo = state == WAIT && !fpu_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  assign done = state == WAIT && (fpu_ready || tmo);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (any_req ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT ? (done ? RESP : WAIT) : IDLE;
    req_ready = state == IDLE ? grant : '0;
    rsp_valid = state == RESP ? NUM_REQ'(1) << ptr : '0;
    fpu_start = state == ISSUE;
    busy = state != IDLE;
  end
  // ptr doubles as the in-flight requester index for response routing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= IW'(NUM_REQ - 1);
      fpu_op <= '0;
      fpu_rmode <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        ptr <= idx;
        fpu_op <= fpu_op_t'(req_op[int'(idx) * 3 +: 3]);
        fpu_rmode <= fpu_rmode_t'(req_rmode[int'(idx) * 2 +: 2]);
        fpu_a <= req_a[int'(idx) * FP_WIDTH +: FP_WIDTH];
        fpu_b <= req_b[int'(idx) * FP_WIDTH +: FP_WIDTH];
      end
      rsp_result <= done ? (fpu_ready ? fpu_result : '1) : '0;
      rsp_err <= done && !fpu_ready;
    end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed self-checking bench for fpu_share_arbiter
module tb_fpu_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [3*N-1:0] req_op;
  logic [2*N-1:0] req_rmode;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] rsp_result, fpu_a, fpu_b;
  logic [W-1:0] fpu_result = '0;
  logic rsp_err, fpu_start, busy;
  logic fpu_ready = 1'b0;
  logic [2:0] fpu_op;
  logic [1:0] fpu_rmode;
  logic [W-1:0] av [N] = '{32'h3F800000, 32'h41200000, 32'hC0A00000, 32'h3E800000};
  logic [W-1:0] bv [N] = '{32'h40000000, 32'h3F000000, 32'h40490FDB, 32'hBF800000};
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fpu_share_arbiter #(.NUM_REQ(N), .FP_WIDTH(W), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rmode(req_rmode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    fpu_ready = 1'b0;
    next;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_start", 32'(fpu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_result", rsp_result, 0);
    next;
    rst = 1'b0;
  endtask

  // One accept/issue/wait/respond sequence; lat = WAIT cycles before ready
  task automatic op(input logic [N-1:0] v, input int g, input logic [31:0] res, input int lat);
    next;
    req_valid = v;
    #1;
    check("grant", 32'(req_ready), 32'(1) << g);
    check("idle_busy", 32'(busy), 0);
    next;
    #1;
    check("start", 32'(fpu_start), 1);
    check("issue_ready", 32'(req_ready), 0);
    check("fpu_a", fpu_a, av[g]);
    check("fpu_b", fpu_b, bv[g]);
    check("fpu_op", 32'(fpu_op), 32'(g));
    check("fpu_rmode", 32'(fpu_rmode), 32'(g % 4));
    repeat (lat) begin
      next;
      #1;
      check("wait_start", 32'(fpu_start), 0);
      check("wait_rsp", 32'(rsp_valid), 0);
    end
    next;
    fpu_ready = 1'b1;
    fpu_result = res;
    #1;
    check("ready_rsp", 32'(rsp_valid), 0);
    next;
    fpu_ready = 1'b0;
    fpu_result = '0;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    check("rsp_result", rsp_result, res);
    check("rsp_err", 32'(rsp_err), 0);
    check("resp_start", 32'(fpu_start), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = 3'(i);
      req_rmode[2*i +: 2] = 2'(i);
      req_a[W*i +: W] = av[i];
      req_b[W*i +: W] = bv[i];
    end
    do_reset;
    op(4'b0001, 0, 32'h40400000, 1);
    next;
    req_valid = '0;
    #1;
    check("after_rsp", 32'(rsp_valid), 0);
    check("after_result", rsp_result, 0);
    check("after_busy", 32'(busy), 0);

    do_reset;
    op(4'b1111, 0, 32'hA0000000, 0);
    op(4'b1111, 1, 32'hA1111111, 2);
    op(4'b1111, 2, 32'hA2222222, 0);
    op(4'b1111, 3, 32'hA3333333, 1);
    op(4'b1111, 0, 32'hA4444444, 0);

    do_reset;
    op(4'b1010, 1, 32'hB1000000, 0);
    op(4'b1010, 3, 32'hB3000000, 0);
    op(4'b1010, 1, 32'hB1000001, 0);

    next;
    req_valid = '0;
    fpu_ready = 1'b1;
    fpu_result = 32'hDEADBEEF;
    #1;
    check("spur_idle_busy", 32'(busy), 0);
    next;
    fpu_ready = 1'b0;
    #1;
    check("spur_idle_busy2", 32'(busy), 0);
    check("spur_idle_rsp", 32'(rsp_valid), 0);
    req_valid = 4'b0010;
    #1;
    check("spur_grant", 32'(req_ready), 32'b0010);
    next;
    fpu_ready = 1'b1;
    #1;
    check("spur_issue_start", 32'(fpu_start), 1);
    next;
    fpu_ready = 1'b0;
    #1;
    check("spur_wait_busy", 32'(busy), 1);
    check("spur_wait_rsp", 32'(rsp_valid), 0);
    next;
    fpu_ready = 1'b1;
    fpu_result = 32'h12345678;
    #1;
    check("spur_wait_rsp2", 32'(rsp_valid), 0);
    next;
    fpu_ready = 1'b0;
    #1;
    check("spur_rsp", 32'(rsp_valid), 32'b0010);
    check("spur_result", rsp_result, 32'h12345678);

    next;
    req_valid = 4'b0100;
    #1;
    check("mid_grant", 32'(req_ready), 32'b0100);
    next;
    req_valid = '0;
    next;
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_fpu_a", fpu_a, 0);
    check("mid_start", 32'(fpu_start), 0);
    next;
    rst = 1'b0;
    next;
    fpu_ready = 1'b1;
    fpu_result = 32'hCAFEF00D;
    #1;
    check("mid_late_busy", 32'(busy), 0);
    next;
    fpu_ready = 1'b0;
    #1;
    check("mid_late_rsp", 32'(rsp_valid), 0);
    check("mid_late_result", rsp_result, 0);
    check("mid_late_busy2", 32'(busy), 0);

    next;
    req_valid = 4'b0001;
    #1;
    check("to_grant", 32'(req_ready), 32'b0001);
    next;
    req_valid = '0;
    #1;
    check("to_start", 32'(fpu_start), 1);
`ifdef FPU_ARB_TIMEOUT_EN
    repeat (10) begin
      next;
      #1;
      check("to_wait_rsp", 32'(rsp_valid), 0);
    end
    next;
    #1;
    check("to_rsp", 32'(rsp_valid), 32'b0001);
    check("to_err", 32'(rsp_err), 1);
    check("to_result", rsp_result, 32'hFFFFFFFF);
    next;
    #1;
    check("to_idle", 32'(busy), 0);
`else
    repeat (20) next;
    #1;
    check("no_to_busy", 32'(busy), 1);
    check("no_to_rsp", 32'(rsp_valid), 0);
    check("no_to_err", 32'(rsp_err), 0);
`endif
    do_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
